// File: rtl/balanca_price_calc_if.sv
// Purpose : bundles the request/result signals of the price calculator.
//   master : drives start, weightInGrams, tareInGrams, centimos; reads results
//   slave  : the calculator; reads the request, drives busy, done, precotara,
//            precof and tare_err
interface balanca_price_calc_if #(
    parameter int WEIGHT_W = 12,
    parameter int PRICE_W  = 12
) ();
    localparam int PROD_W = WEIGHT_W + PRICE_W;

    logic                start;
    logic [WEIGHT_W-1:0] weightInGrams;
    logic [WEIGHT_W-1:0] tareInGrams;
    logic [PRICE_W-1:0]  centimos;
    logic                busy;
    logic                done;
    logic [PROD_W-1:0]   precotara;
    logic [PROD_W-1:0]   precof;
    logic                tare_err;

    modport master (
        output start, weightInGrams, tareInGrams, centimos,
        input  busy, done, precotara, precof, tare_err
    );

    modport slave (
        input  start, weightInGrams, tareInGrams, centimos,
        output busy, done, precotara, precof, tare_err
    );
endinterface

// File: rtl/balanca_price_calc.sv
// Purpose : scale price calculator. Net weight (gross - tare, clamped at 0)
//           is multiplied by the unit price with a serial shift-add multiplier,
//           then divided by GRAMS_PER_KG with a serial restoring divider,
//           optionally rounding half up.
// Ports   : clk, rst_n (async, active-low), bus (balanca_price_calc_if.slave)
//
// state | meaning
// IDLE  | waiting for start; inputs latched on start
// TARE  | net = gross - tare, clamped to 0 with error flag
// MUL   | shift-add multiply, one multiplier bit per cycle (WEIGHT_W cycles)
// DIV   | restoring divide, one quotient bit per cycle (PROD_W cycles)
// DONE  | one-cycle done pulse
module balanca_price_calc #(
    parameter int WEIGHT_W     = 12,
    parameter int PRICE_W      = 12,
    parameter int GRAMS_PER_KG = 1000,
    parameter int ROUND_EN     = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    balanca_price_calc_if.slave bus
);
    localparam int PROD_W = WEIGHT_W + PRICE_W;
    // Remainder is always < GRAMS_PER_KG; one extra bit keeps it safe for
    // any divisor value.
    localparam int REM_W  = $clog2(GRAMS_PER_KG) + 1;
    localparam int CNT_W  = $clog2(PROD_W + 1);

    localparam logic [REM_W:0]  DIVISOR   = (REM_W + 1)'(GRAMS_PER_KG);
    localparam logic [PROD_W:0] ROUND_ADD =
        (ROUND_EN != 0) ? (PROD_W + 1)'(GRAMS_PER_KG / 2) : (PROD_W + 1)'(0);

    typedef enum logic [2:0] {IDLE, TARE, MUL, DIV, DONE} state_t;

    state_t              state;
    logic [WEIGHT_W-1:0] mplier;
    logic [WEIGHT_W-1:0] tare_r;
    logic [PROD_W-1:0]   mcand;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   dvd;     // dividend bits shift out, quotient bits shift in
    logic [REM_W-1:0]    rem;
    logic [CNT_W-1:0]    cnt;
    logic                err_flag;

    logic [PROD_W-1:0]   prod_add;
    logic [PROD_W:0]     dividend;
    logic [REM_W:0]      trial;
    logic                q_bit;
    logic [REM_W:0]      rem_full;

    always_comb begin
        prod_add = prod;
        if (mplier[0]) begin
            prod_add = prod + mcand;
        end
        dividend = {1'b0, prod_add} + ROUND_ADD;
        trial    = {rem, dvd[PROD_W-1]};
        q_bit    = (trial >= DIVISOR);
        rem_full = trial;
        if (q_bit) begin
            rem_full = trial - DIVISOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mplier        <= '0;
            tare_r        <= '0;
            mcand         <= '0;
            prod          <= '0;
            dvd           <= '0;
            rem           <= '0;
            cnt           <= '0;
            err_flag      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.precotara <= '0;
            bus.precof    <= '0;
            bus.tare_err  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mplier   <= bus.weightInGrams;
                        tare_r   <= bus.tareInGrams;
                        mcand    <= {{(PROD_W - PRICE_W){1'b0}}, bus.centimos};
                        bus.busy <= 1'b1;
                        state    <= TARE;
                    end
                end
                TARE: begin
                    if (tare_r > mplier) begin
                        mplier   <= '0;
                        err_flag <= 1'b1;
                    end else begin
                        mplier   <= mplier - tare_r;
                        err_flag <= 1'b0;
                    end
                    prod  <= '0;
                    cnt   <= CNT_W'(WEIGHT_W - 1);
                    state <= MUL;
                end
                MUL: begin
                    // prod keeps the unrounded product for precotara
                    prod   <= prod_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == '0) begin
                        // dividend MSB seeds the remainder; it is below the
                        // divisor, so that quotient bit is always 0
                        rem   <= {{(REM_W - 1){1'b0}}, dividend[PROD_W]};
                        dvd   <= dividend[PROD_W-1:0];
                        cnt   <= CNT_W'(PROD_W - 1);
                        state <= DIV;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_full[REM_W-1:0];
                    dvd <= {dvd[PROD_W-2:0], q_bit};
                    if (cnt == '0) begin
                        bus.precof    <= {dvd[PROD_W-2:0], q_bit};
                        bus.precotara <= prod;
                        bus.tare_err  <= err_flag;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_balanca_price_calc.sv
// Purpose : scoreboard bench for balanca_price_calc; one truncating and one
//           rounding instance run the same stimulus side by side.
module tb_balanca_price_calc;
    localparam int PROD_W = 24;

    typedef struct {
        logic [PROD_W-1:0] pc;
        logic [PROD_W-1:0] pf;
        logic              err;
        int                cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   done_cnt [2];
    exp_t sb [2][$];

    balanca_price_calc_if bus0 ();
    balanca_price_calc_if bus1 ();

    balanca_price_calc #(.ROUND_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    balanca_price_calc #(.ROUND_EN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, want);
    endtask

    function automatic exp_t model(input int w, input int t, input int p, input int rnd, input int c);
        exp_t e;
        longint net, prod;
        net   = (t > w) ? 0 : w - t;
        prod  = net * p;
        e.pc  = PROD_W'(prod);
        e.pf  = PROD_W'((prod + (rnd != 0 ? 500 : 0)) / 1000);
        e.err = (t > w);
        e.cyc = c;
        return e;
    endfunction

    task automatic on_done(input int id, input logic [PROD_W-1:0] pc, input logic [PROD_W-1:0] pf,
                           input logic err, input logic busy);
        exp_t e;
        done_cnt[id]++;
        if (sb[id].size() == 0) begin
            check_val($sformatf("unexpected_done%0d", id), 1, 0);
        end else begin
            e = sb[id].pop_front();
            check_val($sformatf("precotara%0d", id), pc, e.pc);
            check_val($sformatf("precof%0d", id), pf, e.pf);
            check_val($sformatf("tare_err%0d", id), err, e.err);
            check_val($sformatf("latency%0d", id), cyc, e.cyc);
            check_val($sformatf("busy_at_done%0d", id), busy, 0);
        end
    endtask

    always @(negedge clk) if (bus0.done) on_done(0, bus0.precotara, bus0.precof, bus0.tare_err, bus0.busy);
    always @(negedge clk) if (bus1.done) on_done(1, bus1.precotara, bus1.precof, bus1.tare_err, bus1.busy);

    task automatic set_in(input int w, input int t, input int p);
        bus0.weightInGrams = 12'(w); bus1.weightInGrams = 12'(w);
        bus0.tareInGrams   = 12'(t); bus1.tareInGrams   = 12'(t);
        bus0.centimos      = 12'(p); bus1.centimos      = 12'(p);
    endtask

    task automatic set_start(input logic s);
        bus0.start = s;
        bus1.start = s;
    endtask

    // Call at a negedge with both DUTs idle; start is sampled on the next edge.
    task automatic run_calc(input int w, input int t, input int p);
        int c;
        set_in(w, t, p);
        set_start(1'b1);
        @(posedge clk); #1;
        c = cyc;
        sb[0].push_back(model(w, t, p, 0, c + 37));
        sb[1].push_back(model(w, t, p, 1, c + 37));
        check_val("busy_after_start0", bus0.busy, 1);
        check_val("busy_after_start1", bus1.busy, 1);
        set_start(1'b0);
        // later input changes must not disturb the running calculation
        set_in($urandom_range(4095), $urandom_range(4095), $urandom_range(4095));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 90) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("drain_timeout", sb[0].size() + sb[1].size(), 0);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_busy0"}, bus0.busy, 0);
        check_val({tag, "_done0"}, bus0.done, 0);
        check_val({tag, "_pc0"}, bus0.precotara, 0);
        check_val({tag, "_pf0"}, bus0.precof, 0);
        check_val({tag, "_err0"}, bus0.tare_err, 0);
        check_val({tag, "_pc1"}, bus1.precotara, 0);
        check_val({tag, "_pf1"}, bus1.precof, 0);
    endtask

    initial begin
        int d0, d1, c, n;
        n_checks = 0;
        n_pass   = 0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        rst_n = 1'b0;
        set_start(1'b0);
        set_in(0, 0, 0);
        repeat (3) @(negedge clk);
        #1 check_zero("reset");

        // first start accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        run_calc(1500, 0, 470);
        drain();
        check_val("hold_pf0", bus0.precof, 705);
        check_val("hold_pc0", bus0.precotara, 705000);

        run_calc(1500, 200, 470);   drain();
        run_calc(1234, 0, 470);     drain();
        run_calc(1500, 1600, 470);  drain();
        run_calc(1500, 1500, 470);  drain();
        run_calc(0, 0, 4095);       drain();
        for (int i = 0; i < 4; i++) begin
            run_calc($urandom_range(4095), $urandom_range(2000), $urandom_range(4095));
            drain();
        end

        // max operands, then start during busy and during DONE is ignored
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        run_calc(4095, 0, 4095);
        repeat (5) @(negedge clk);
        set_start(1'b1);
        repeat (10) @(negedge clk);
        set_start(1'b0);
        n = 0;
        while (!bus0.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", bus0.done, 1);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (45) @(negedge clk);
        check_val("one_done0", done_cnt[0] - d0, 1);
        check_val("one_done1", done_cnt[1] - d1, 1);
        check_val("no_pending", sb[0].size() + sb[1].size(), 0);

        // start held high relaunches on the edge after DONE
        set_in(1500, 200, 470);
        set_start(1'b1);
        @(posedge clk); #1;
        c = cyc;
        for (int k = 0; k < 2; k++) begin
            sb[0].push_back(model(1500, 200, 470, 0, c + 37 + k * 39));
            sb[1].push_back(model(1500, 200, 470, 1, c + 37 + k * 39));
        end
        repeat (39) @(posedge clk);
        #1;
        check_val("relaunch_busy", bus0.busy, 1);
        @(negedge clk);
        set_start(1'b0);
        drain();

        // reset in the middle of a calculation
        d0 = done_cnt[0];
        run_calc(1500, 0, 470);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("midreset");
        sb[0].delete();
        sb[1].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check_val("no_done_after_abort", done_cnt[0] - d0, 0);
        check_val("idle_after_abort", bus0.busy, 0);
        run_calc(1500, 0, 470);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/balanca_price_calc.md
BALANCA_PRICE_CALC -- requirements
Module: balanca_price_calc

Interface
REQ-001 The block SHALL have parameter WEIGHT_W, default 12, meaning width of weight and tare in grams.
REQ-002 The block SHALL have parameter PRICE_W, default 12, meaning width of unit price in cents per kg.
REQ-003 The block SHALL have parameter GRAMS_PER_KG, default 1000, meaning the constant divisor (must be >= 2).
REQ-004 The block SHALL have parameter ROUND_EN, default 0, meaning 0 = truncate quotient, 1 = round half up.
REQ-005 The block SHALL have derived localparam PROD_W = WEIGHT_W + PRICE_W, the product and result width.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port start, input, 1 bit: request a new calculation, sampled only in IDLE.
REQ-009 Port weightInGrams, input, WEIGHT_W bits: gross weight in grams.
REQ-010 Port tareInGrams, input, WEIGHT_W bits: tare weight in grams.
REQ-011 Port centimos, input, PRICE_W bits: unit price in cents per kg.
REQ-012 Port busy, output, 1 bit: high while a calculation is in progress (states TARE, MUL, DIV).
REQ-013 Port done, output, 1 bit: single-cycle pulse when results are valid.
REQ-014 Port precotara, output, PROD_W bits: registered net_weight * centimos.
REQ-015 Port precof, output, PROD_W bits: registered final price in cents.
REQ-016 Port tare_err, output, 1 bit: registered flag, tare exceeded gross weight.

Function
REQ-017 The FSM SHALL have states IDLE, TARE, MUL, DIV, DONE.
REQ-018 In IDLE with start=1, the block SHALL latch weightInGrams, tareInGrams and centimos and go to TARE; with start=0 it SHALL stay in IDLE.
REQ-019 In TARE (one cycle), the block SHALL compute net = weight - tare; if tare > weight it SHALL set net = 0 and tare_err = 1, otherwise tare_err = 0.
REQ-020 MUL SHALL be a shift-add multiply, one multiplier bit per cycle, exactly WEIGHT_W cycles.
REQ-021 The product SHALL be exact in PROD_W bits, with no overflow possible.
REQ-022 On the last MUL cycle, the dividend SHALL be product + (ROUND_EN ? GRAMS_PER_KG/2 : 0), held in a PROD_W+1 bit register.
REQ-023 DIV SHALL be restoring division by GRAMS_PER_KG, one quotient bit per cycle, exactly PROD_W cycles.
REQ-024 On the last DIV cycle, precof SHALL take the quotient and precotara SHALL take the unrounded product; the FSM SHALL go to DONE.
REQ-025 In DONE (one cycle), done SHALL be 1, and the FSM SHALL go to IDLE on the next edge.
REQ-026 Latency: with start sampled at edge k, done SHALL be high during the cycle after edge k+1+WEIGHT_W+PROD_W (k+37 for defaults).
REQ-027 busy SHALL be high from edge k until edge k+1+WEIGHT_W+PROD_W.
REQ-028 start asserted outside IDLE (including DONE) SHALL be ignored and not queued.
REQ-029 Input changes after the start sample SHALL NOT affect the running calculation.
REQ-030 precotara, precof and tare_err SHALL hold their values until the next DONE.
REQ-031 start held high continuously SHALL re-launch a calculation on the cycle after DONE, i.e. the edge on which the FSM is in IDLE.

Reset
REQ-032 On rst_n=0 (asynchronous), the block SHALL immediately set state = IDLE, busy = 0, done = 0, precotara = 0, precof = 0, tare_err = 0, and clear all internal registers.
REQ-033 On reset mid-calculation, the block SHALL abort the calculation with no done pulse, and outputs SHALL read 0.
REQ-034 After reset release, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-035 Scenario: weight=1500, tare=0, price=470, ROUND_EN=0 -> precotara=705000, precof=705, tare_err=0, done exactly 37 edges after the start edge.
REQ-036 Scenario: weight=1500, tare=200, price=470 -> precotara=611000, precof=611, tare_err=0.
REQ-037 Scenario: weight=1234, tare=0, price=470 -> precotara=579980; precof=579 with ROUND_EN=0 and precof=580 with ROUND_EN=1.
REQ-038 Scenario: weight=1500, tare=1600, price=470 -> tare_err=1, precotara=0, precof=0, done still pulses.
REQ-039 Scenario: weight=4095, tare=0, price=4095 -> precotara=16769025, precof=16769 in both rounding modes; then a second start during busy is ignored (exactly one done pulse).
REQ-040 Scenario: rst_n low at cycle 20 of a calculation -> busy=0, done never pulses, outputs 0; a fresh start of 1500/0/470 then yields precof=705.
